pipe_latch_skid: RTL and testbench
==================================

Name: pipe_latch_skid

Overview:
- Parametrised successor to the fixed multdiv-to-writeback pipeline latch.
- Carries instruction word, result payload and exception flags between pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered and no bubbles are lost on stalls.
- Adds flush and occupancy tracking; drop-in for any stage boundary in the processor.

Parameters:
IR_W, 32, instruction-register width
DATA_W, 32, payload (P) width
EXC_W, 1, exception-flag vector width (multdiv exception = bit 0)

Ports:
clk  in  1  pipeline clock; all state updates on falling edge
reset  in  1  synchronous, active-low reset (0 = reset), sampled on falling edge
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  latch can accept (registered)
in_IR  in  IR_W  instruction in
in_P  in  DATA_W  payload in
in_exc  in  EXC_W  exception flags in
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_IR  out  IR_W  instruction out
out_P  out  DATA_W  payload out
out_exc  out  EXC_W  exception flags out
out_exc_any  out  1  OR-reduction of out_exc, gated by out_valid

Behaviour:
- Accept = in_valid & in_ready; fire = out_valid & out_ready.
- Storage: main entry (drives outputs) plus skid entry.
- FSM states: EMPTY, ONE (main valid), FULL (main + skid valid).
- EMPTY:
  - accept -> load main, go to ONE.
  - fire is impossible.
- ONE:
  - accept & fire -> main <= input, stay ONE.
  - accept & !fire -> skid <= input, go to FULL.
  - !accept & fire -> EMPTY.
  - otherwise hold.
- FULL:
  - in_ready = 0.
  - fire -> main <= skid, go to ONE.
  - otherwise hold.
- in_ready = (state != FULL), driven from a register, never from out_ready combinationally.
- Latency: accept on edge N gives out_valid after edge N, i.e. 1 cycle. Throughput is 1 per cycle when out_ready is held high.
- flush: next state EMPTY; overrides accept and fire in the same cycle. Data registers hold stale values.
- reset low: state EMPTY; all data registers, out_IR, out_P and out_exc = 0; in_ready = 1; out_valid = 0; out_exc_any = 0. Reset has priority over flush.
- Reset or flush while FULL discards both entries, with no partial transfer.
- Output data is stable while out_valid & !out_ready (no change until fire).
- out_exc_any = out_valid & |out_exc.

Optional Feature:
- Macro PIPE_LATCH_STALL_CNT_EN.
- Defined: adds output stall_cycles (32 bits).
  - Increments every falling edge where out_valid & !out_ready; saturates at all-ones.
  - Cleared by reset; not cleared by flush.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package pipe_latch_pkg:
  - state enum (EMPTY/ONE/FULL), 2 bits.
  - default width constants (IR_W, DATA_W, EXC_W).
  - NOP_IR constant = 0.
- Sub-module pipe_latch_entry: one falling-edge register bundle (IR, P, exc) with write_enable and active-low synchronous reset. Instantiated twice (main, skid).
- FSM and handshake logic live in the top level.

Test Plan:
- Reset then stream: hold reset=0 for 2 edges, release; out_ready=1; send IR=0x00000001..0x00000004 with P=0xA0..0xA3 on consecutive cycles -> each appears 1 cycle later in order, out_valid continuous, in_ready stays 1.
- Backpressure fill: out_ready=0; send IR=0x11, then 0x22 -> in_ready=0 after 2nd accept, out_IR=0x11 held stable; raise out_ready -> 0x11 then 0x22 delivered, in_ready=1 again.
- Flush while FULL: fill with 0x33 and 0x44; assert flush together with in_valid (IR=0x55) -> next cycle out_valid=0, in_ready=1, 0x55 not captured.
- Exception propagation: EXC_W=3, send in_exc=3'b100 with P=0xDEAD -> out_exc=3'b100, out_exc_any=1; after drain, out_exc_any=0 despite stale out_exc.
- Reset mid-operation: in FULL, drive reset=0 for 1 edge -> out_valid=0, out_IR=0, out_P=0, out_exc=0, in_ready=1; reset priority confirmed with flush=1 simultaneously.
- With PIPE_LATCH_STALL_CNT_EN: hold a valid entry with out_ready=0 for 7 cycles -> stall_cycles=7; flush -> still 7; reset -> 0.

Source files
------------

// File: rtl/pipe_latch_pkg.sv
// Shared types and defaults for the skid-buffered pipeline latch.
// Imported by the interface, the entry register and the top level.
package pipe_latch_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEF_IR_W   = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_EXC_W  = 1;

  localparam logic [DEF_IR_W-1:0] NOP_IR = '0;

endpackage

// File: rtl/pipe_latch_skid_if.sv
// Upstream/downstream valid-ready bundle for pipe_latch_skid.
// master drives inputs and out_ready; slave is the latch side.
interface pipe_latch_skid_if
  import pipe_latch_pkg::*;
#(
  parameter int IR_W   = DEF_IR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXC_W  = DEF_EXC_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [IR_W-1:0]   in_IR;
  logic [DATA_W-1:0] in_P;
  logic [EXC_W-1:0]  in_exc;

  logic              out_valid;
  logic              out_ready;
  logic [IR_W-1:0]   out_IR;
  logic [DATA_W-1:0] out_P;
  logic [EXC_W-1:0]  out_exc;
  logic              out_exc_any;

  modport master (
    output in_valid, in_IR, in_P, in_exc, out_ready,
    input  in_ready, out_valid, out_IR, out_P,
    input  out_exc, out_exc_any
  );

  modport slave (
    input  in_valid, in_IR, in_P, in_exc, out_ready,
    output in_ready, out_valid, out_IR, out_P,
    output out_exc, out_exc_any
  );

endinterface

// File: rtl/pipe_latch_entry.sv
// One falling-edge storage slot (IR, payload, exception flags)
// with write enable and synchronous active-low reset.
module pipe_latch_entry
  import pipe_latch_pkg::*;
#(
  parameter int IR_W   = DEF_IR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXC_W  = DEF_EXC_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IR_W-1:0]   ir_i,
  input  logic [DATA_W-1:0] p_i,
  input  logic [EXC_W-1:0]  exc_i,
  output logic [IR_W-1:0]   ir_o,
  output logic [DATA_W-1:0] p_o,
  output logic [EXC_W-1:0]  exc_o
);

  logic [IR_W-1:0]   ir_q;
  logic [DATA_W-1:0] p_q;
  logic [EXC_W-1:0]  exc_q;

  always_ff @(negedge clk_i) begin
    if (!rst_ni) begin
      ir_q  <= IR_W'(NOP_IR);
      p_q   <= '0;
      exc_q <= '0;
    end else if (we_i) begin
      ir_q  <= ir_i;
      p_q   <= p_i;
      exc_q <= exc_i;
    end
  end

  assign ir_o  = ir_q;
  assign p_o   = p_q;
  assign exc_o = exc_q;

endmodule

// File: rtl/pipe_latch_skid.sv
// Two-entry skid pipeline latch with registered in_ready and flush.
// Optional stall counter enabled by PIPE_LATCH_STALL_CNT_EN.
module pipe_latch_skid
  import pipe_latch_pkg::*;
#(
  parameter int IR_W   = DEF_IR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int EXC_W  = DEF_EXC_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  pipe_latch_skid_if.slave bus
`ifdef PIPE_LATCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   out_valid;
  logic   accept, fire;
  logic   main_we, skid_we, from_skid;

  logic [IR_W-1:0]   skid_ir, main_ir_d;
  logic [DATA_W-1:0] skid_p, main_p_d;
  logic [EXC_W-1:0]  skid_exc, main_exc_d;

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign fire      = out_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    main_we   = 1'b0;
    skid_we   = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_we = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & fire: main_we = 1'b1;
            accept & !fire: begin
              skid_we = 1'b1;
              state_d = FULL;
            end
            !accept & fire: state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (fire) begin
            main_we   = 1'b1;
            from_skid = 1'b1;
            state_d   = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // in_ready comes straight from a flop so it never sees out_ready.
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign main_ir_d  = from_skid ? skid_ir  : bus.in_IR;
  assign main_p_d   = from_skid ? skid_p   : bus.in_P;
  assign main_exc_d = from_skid ? skid_exc : bus.in_exc;

  pipe_latch_entry #(
    .IR_W(IR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)
  ) u_main (
    .clk_i  (clk),
    .rst_ni (reset),
    .we_i   (main_we),
    .ir_i   (main_ir_d),
    .p_i    (main_p_d),
    .exc_i  (main_exc_d),
    .ir_o   (bus.out_IR),
    .p_o    (bus.out_P),
    .exc_o  (bus.out_exc)
  );

  pipe_latch_entry #(
    .IR_W(IR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)
  ) u_skid (
    .clk_i  (clk),
    .rst_ni (reset),
    .we_i   (skid_we),
    .ir_i   (bus.in_IR),
    .p_i    (bus.in_P),
    .exc_i  (bus.in_exc),
    .ir_o   (skid_ir),
    .p_o    (skid_p),
    .exc_o  (skid_exc)
  );

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_exc_any = out_valid & (|bus.out_exc);

`ifdef PIPE_LATCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && !(&stall_q)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Survives flush on purpose; only reset clears it.
  always_ff @(negedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Randomised + directed bench for pipe_latch_skid.
// Queue-based occupancy model with scoreboard monitor.
module tb_pipe_latch_skid;

  localparam int IR_W   = 32;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 3;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] p;
    logic [EXC_W-1:0]  exc;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  pipe_latch_skid_if #(
    .IR_W(IR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)
  ) bus ();

`ifdef PIPE_LATCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pipe_latch_skid #(
    .IR_W(IR_W), .DATA_W(DATA_W), .EXC_W(EXC_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_LATCH_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  item_t       exp_q[$];
  int          occ_pre = 0;
  int unsigned stall_exp = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the held-entry queue head against the DUT.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      occ_pre = exp_q.size();
      if (mon_en) begin
        chk("mon_in_ready", 64'(bus.in_ready), 64'(occ_pre < 2));
        chk("mon_out_valid", 64'(bus.out_valid), 64'(occ_pre > 0));
        if (occ_pre > 0) begin
          chk("mon_out_IR", 64'(bus.out_IR), 64'(exp_q[0].ir));
          chk("mon_out_P", 64'(bus.out_P), 64'(exp_q[0].p));
          chk("mon_out_exc", 64'(bus.out_exc), 64'(exp_q[0].exc));
          chk("mon_exc_any", 64'(bus.out_exc_any),
              64'(|exp_q[0].exc));
        end else begin
          chk("mon_exc_any", 64'(bus.out_exc_any), 64'd0);
        end
`ifdef PIPE_LATCH_STALL_CNT_EN
        chk("mon_stall", 64'(stall_cycles), 64'(stall_exp));
`endif
      end
      if (reset && !flush && occ_pre > 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // Model: pushes each accepted item, applies reset/flush.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        exp_q.delete();
        stall_exp = 0;
      end else begin
        if (occ_pre > 0 && !bus.out_ready && stall_exp != 32'hFFFF_FFFF)
          stall_exp++;
        if (flush) begin
          exp_q.delete();
        end else if (bus.in_valid && occ_pre < 2) begin
          it.ir  = bus.in_IR;
          it.p   = bus.in_P;
          it.exc = bus.in_exc;
          exp_q.push_back(it);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ir,
                       input logic [31:0] p, input logic [2:0] exc);
    bus.in_valid = v;
    bus.in_IR    = ir;
    bus.in_P     = p;
    bus.in_exc   = exc;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_IR", 64'(bus.out_IR), 64'd0);
    chk("rst_out_P", 64'(bus.out_P), 64'd0);
    chk("rst_out_exc", 64'(bus.out_exc), 64'd0);
    chk("rst_exc_any", 64'(bus.out_exc_any), 64'd0);
    mon_en = 1'b1;
    reset = 1'b1;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i + 1), 32'(32'hA0 + i), 3'b000);
      @(posedge clk);
      chk("stream_IR", 64'(bus.out_IR), 64'(i + 1));
      chk("stream_P", 64'(bus.out_P), 64'(32'hA0 + i));
    end
    drive(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);

    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 32'h1, 3'b000);
    @(posedge clk);
    drive(1'b1, 32'h22, 32'h2, 3'b000);
    @(posedge clk);
    drive(1'b0, '0, '0, '0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_IR", 64'(bus.out_IR), 64'h11);
    @(posedge clk);
    chk("bp_hold_IR2", 64'(bus.out_IR), 64'h11);
    bus.out_ready = 1'b1;
    @(posedge clk);
    chk("bp_second_IR", 64'(bus.out_IR), 64'h22);
    chk("bp_in_ready2", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    bus.out_ready = 1'b0;
    drive(1'b1, 32'h33, 32'h3, 3'b000);
    @(posedge clk);
    drive(1'b1, 32'h44, 32'h4, 3'b000);
    @(posedge clk);
    drive(1'b1, 32'h55, 32'h5, 3'b000);
    flush = 1'b1;
    @(posedge clk);
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    chk("fl_stale_IR", 64'(bus.out_IR), 64'h33);
    @(posedge clk);
    chk("fl_no_capture", 64'(bus.out_valid), 64'd0);

    drive(1'b1, 32'h66, 32'hDEAD, 3'b100);
    @(posedge clk);
    drive(1'b0, '0, '0, '0);
    chk("exc_val", 64'(bus.out_exc), 64'd4);
    chk("exc_any", 64'(bus.out_exc_any), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    chk("exc_stale", 64'(bus.out_exc), 64'd4);
    chk("exc_any_gated", 64'(bus.out_exc_any), 64'd0);

    bus.out_ready = 1'b0;
    drive(1'b1, 32'h77, 32'h7, 3'b001);
    @(posedge clk);
    drive(1'b1, 32'h88, 32'h8, 3'b010);
    @(posedge clk);
    drive(1'b0, '0, '0, '0);
    reset = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    reset = 1'b1;
    flush = 1'b0;
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_out_IR", 64'(bus.out_IR), 64'd0);
    chk("mr_out_P", 64'(bus.out_P), 64'd0);
    chk("mr_out_exc", 64'(bus.out_exc), 64'd0);
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);

`ifdef PIPE_LATCH_STALL_CNT_EN
    drive(1'b1, 32'h99, 32'h9, 3'b000);
    @(posedge clk);
    drive(1'b0, '0, '0, '0);
    repeat (7) @(posedge clk);
    chk("stall_7", 64'(stall_cycles), 64'd7);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    flush = 1'b0;
    chk("stall_flush", 64'(stall_cycles), 64'd7);
    reset = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    chk("stall_reset", 64'(stall_cycles), 64'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            3'($urandom_range(0, 7)));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 199) != 0);
      @(posedge clk);
    end
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    flush = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
